// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
//
// Packet-level round-robin arbiter in front of one shared 2:1 data mux.
// Two valid/ready requesters compete for a single registered output stage.
// A grant lasts until the granted requester delivers its Last beat, or until
// MAX_BEATS beats have been accepted. When the packet is cut at MAX_BEATS,
// the output beat is marked Last and Truncated pulses for one cycle. On a
// tie, the requester that was not granted most recently wins.
//
// Ports:
//   Clk        - system clock, rising edge
//   Rst_n      - asynchronous active-low reset
//   In0_Valid  - requester 0 beat valid
//   In0_Data   - requester 0 beat data (WIDTH bits)
//   In0_Last   - requester 0 final beat of packet
//   In0_Ready  - requester 0 beat accepted when high with In0_Valid
//   In1_Valid  - requester 1 beat valid
//   In1_Data   - requester 1 beat data (WIDTH bits)
//   In1_Last   - requester 1 final beat of packet
//   In1_Ready  - requester 1 beat accepted when high with In1_Valid
//   Out_Valid  - output beat valid
//   Out_Data   - output beat data (WIDTH bits)
//   Out_Last   - output final beat of packet
//   Out_Ready  - downstream accepts the output beat
//   Sel        - mux select: 0 = requester 0, 1 = requester 1
//   Busy       - a grant is active
//   Truncated  - one-cycle pulse when a packet is cut at MAX_BEATS

module mux2_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In0_Valid,
  input  logic [WIDTH-1:0] In0_Data,
  input  logic             In0_Last,
  output logic             In0_Ready,
  input  logic             In1_Valid,
  input  logic [WIDTH-1:0] In1_Data,
  input  logic             In1_Last,
  output logic             In1_Ready,
  output logic             Out_Valid,
  output logic [WIDTH-1:0] Out_Data,
  output logic             Out_Last,
  input  logic             Out_Ready,
  output logic             Sel,
  output logic             Busy,
  output logic             Truncated
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_q;
  logic             ptr_q;       // requester granted most recently
  logic [CW-1:0]    count_q;     // beats accepted in the current packet
  logic             outValid_q;
  logic [WIDTH-1:0] outData_q;
  logic             outLast_q;
  logic             trunc_q;

  logic             outFree;
  logic             muxValid;
  logic [WIDTH-1:0] muxData;
  logic             muxLast;
  logic             accept;
  logic             forced;
  logic             outLast_d;
  logic             release_d;

  // The output stage can take a new beat when it is empty or is being
  // drained this cycle, which gives one beat per cycle within a packet.
  assign outFree   = ~outValid_q | Out_Ready;
  assign In0_Ready = (state_q == GNT0) & outFree;
  assign In1_Ready = (state_q == GNT1) & outFree;

  assign Sel  = (state_q == GNT1);
  assign Busy = (state_q != IDLE);

  // The shared 2:1 mux, steered by the current grant.
  assign muxValid = Sel ? In1_Valid : In0_Valid;
  assign muxData  = Sel ? In1_Data  : In0_Data;
  assign muxLast  = Sel ? In1_Last  : In0_Last;

  assign accept    = Busy & muxValid & outFree;
  // The MAX_BEATS-th beat without a Last closes the packet by force.
  assign forced    = (count_q == CW'(MAX_BEATS - 1)) & ~muxLast;
  assign outLast_d = muxLast | forced;
  assign release_d = accept & outLast_d;

  // Grant state machine plus the registered output stage. The pointer only
  // moves on a grant decision; a release leaves it where it was so the
  // next tie goes to the other requester.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b1;
      count_q    <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      trunc_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (In0_Valid && In1_Valid) begin
            if (ptr_q) begin
              state_q <= GNT0;
              ptr_q   <= 1'b0;
            end else begin
              state_q <= GNT1;
              ptr_q   <= 1'b1;
            end
          end else if (In0_Valid) begin
            state_q <= GNT0;
            ptr_q   <= 1'b0;
          end else if (In1_Valid) begin
            state_q <= GNT1;
            ptr_q   <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (release_d) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (accept) begin
        outValid_q <= 1'b1;
        outData_q  <= muxData;
        outLast_q  <= outLast_d;
        trunc_q    <= forced;
        count_q    <= release_d ? '0 : count_q + 1'b1;
      end else if (Out_Ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign Out_Valid = outValid_q;
  assign Out_Data  = outData_q;
  assign Out_Last  = outLast_q;
  assign Truncated = trunc_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter
//
// Directed testbench for mux2_rr_arbiter (WIDTH=4, MAX_BEATS=8). Each
// scenario task drives requester queues and compares the observed output
// stream, grant order and status flags against hand-computed values.

module tb_mux2_rr_arbiter;

  logic       Clk;
  logic       Rst_n;
  logic       In0_Valid;
  logic [3:0] In0_Data;
  logic       In0_Last;
  logic       In0_Ready;
  logic       In1_Valid;
  logic [3:0] In1_Data;
  logic       In1_Last;
  logic       In1_Ready;
  logic       Out_Valid;
  logic [3:0] Out_Data;
  logic       Out_Last;
  logic       Out_Ready;
  logic       Sel;
  logic       Busy;
  logic       Truncated;

  int assertCount = 0;
  int failCount   = 0;

  // Pending beats per requester; the head is driven until accepted.
  logic [3:0] q0Data[$];
  logic       q0Last[$];
  logic [3:0] q1Data[$];
  logic       q1Last[$];

  // What was observed during runCycles.
  logic [3:0] outDataLog[$];
  logic       outLastLog[$];
  int         accLog[$];
  logic       selLog[$];
  int         protoErr;
  int         truncCount;
  logic [3:0] truncData;
  logic       truncLast;

  mux2_rr_arbiter #(.WIDTH(4), .MAX_BEATS(8)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In0_Valid (In0_Valid),
    .In0_Data  (In0_Data),
    .In0_Last  (In0_Last),
    .In0_Ready (In0_Ready),
    .In1_Valid (In1_Valid),
    .In1_Data  (In1_Data),
    .In1_Last  (In1_Last),
    .In1_Ready (In1_Ready),
    .Out_Valid (Out_Valid),
    .Out_Data  (Out_Data),
    .Out_Last  (Out_Last),
    .Out_Ready (Out_Ready),
    .Sel       (Sel),
    .Busy      (Busy),
    .Truncated (Truncated)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Clears all bookkeeping, then applies a reset and releases it away from
  // the clock edge. Returns 1 time unit after a rising edge.
  task automatic applyReset();
    Rst_n     = 1'b0;
    In0_Valid = 1'b0;
    In0_Data  = '0;
    In0_Last  = 1'b0;
    In1_Valid = 1'b0;
    In1_Data  = '0;
    In1_Last  = 1'b0;
    Out_Ready = 1'b1;
    q0Data.delete(); q0Last.delete();
    q1Data.delete(); q1Last.delete();
    outDataLog.delete(); outLastLog.delete();
    accLog.delete(); selLog.delete();
    protoErr   = 0;
    truncCount = 0;
    truncData  = '0;
    truncLast  = 1'b0;
    repeat (2) @(posedge Clk);
    #3 Rst_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  // Drives the requester queues for n cycles, logging accepted input beats,
  // drained output beats and Truncated pulses. Also counts cycles where a
  // Ready is high for a requester that does not hold the grant.
  task automatic runCycles(input int n);
    logic       acc0, acc1, outAcc, selNow, ol;
    logic [3:0] od;
    for (int c = 0; c < n; c++) begin
      In0_Valid = (q0Data.size() > 0);
      In0_Data  = '0;
      In0_Last  = 1'b0;
      if (q0Data.size() > 0) begin
        In0_Data = q0Data[0];
        In0_Last = q0Last[0];
      end
      In1_Valid = (q1Data.size() > 0);
      In1_Data  = '0;
      In1_Last  = 1'b0;
      if (q1Data.size() > 0) begin
        In1_Data = q1Data[0];
        In1_Last = q1Last[0];
      end
      #1;
      acc0   = In0_Valid & In0_Ready;
      acc1   = In1_Valid & In1_Ready;
      outAcc = Out_Valid & Out_Ready;
      od     = Out_Data;
      ol     = Out_Last;
      selNow = Sel;
      if ((!Busy && (In0_Ready || In1_Ready)) ||
          (Busy && !Sel && In1_Ready) ||
          (Busy && Sel && In0_Ready))
        protoErr++;
      @(posedge Clk);
      #1;
      if (acc0) begin
        void'(q0Data.pop_front());
        void'(q0Last.pop_front());
        accLog.push_back(0);
        selLog.push_back(selNow);
      end
      if (acc1) begin
        void'(q1Data.pop_front());
        void'(q1Last.pop_front());
        accLog.push_back(1);
        selLog.push_back(selNow);
      end
      if (outAcc) begin
        outDataLog.push_back(od);
        outLastLog.push_back(ol);
      end
      if (Truncated) begin
        truncCount++;
        truncData = Out_Data;
        truncLast = Out_Last;
      end
    end
  endtask

  // Outputs must be zero while reset is held.
  task automatic test_reset();
    Rst_n     = 1'b0;
    In0_Valid = 1'b1;
    In0_Data  = 4'h5;
    In0_Last  = 1'b0;
    In1_Valid = 1'b1;
    In1_Data  = 4'h6;
    In1_Last  = 1'b0;
    Out_Ready = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    assertCount++;
    if ({Out_Valid, Out_Data, Out_Last, Sel, Busy, Truncated, In0_Ready, In1_Ready} !== 11'b0) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {Out_Valid, Out_Data, Out_Last, Sel, Busy, Truncated, In0_Ready, In1_Ready}, 11'b0);
    end
    applyReset();
    assertCount++;
    if (Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_idle: Busy got %b expected 0", Busy);
    end
  endtask

  // Three-beat packet from requester 0, cycle-accurate latency checks.
  task automatic test_single_packet();
    applyReset();
    q0Data = '{4'h1, 4'h2, 4'h3};
    q0Last = '{1'b0, 1'b0, 1'b1};
    runCycles(1);
    assertCount++;
    if ({Busy, Sel, Out_Valid, In0_Ready} !== 4'b1001) begin
      failCount++;
      $display("[TB] FAIL single_grant: {Busy,Sel,Out_Valid,In0_Ready} got %b expected 1001",
               {Busy, Sel, Out_Valid, In0_Ready});
    end
    runCycles(1);
    assertCount++;
    if ({Out_Valid, Out_Data, Out_Last} !== {1'b1, 4'h1, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL single_beat1: got %b expected %b", {Out_Valid, Out_Data, Out_Last}, {1'b1, 4'h1, 1'b0});
    end
    runCycles(1);
    assertCount++;
    if ({Out_Valid, Out_Data, Out_Last} !== {1'b1, 4'h2, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL single_beat2: got %b expected %b", {Out_Valid, Out_Data, Out_Last}, {1'b1, 4'h2, 1'b0});
    end
    runCycles(1);
    assertCount++;
    if ({Out_Valid, Out_Data, Out_Last, Busy} !== {1'b1, 4'h3, 1'b1, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL single_beat3: got %b expected %b", {Out_Valid, Out_Data, Out_Last, Busy}, {1'b1, 4'h3, 1'b1, 1'b0});
    end
    runCycles(1);
    assertCount++;
    if ({Out_Valid, Out_Data, Busy, In0_Ready} !== {1'b0, 4'h3, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL single_drain: got %b expected %b", {Out_Valid, Out_Data, Busy, In0_Ready}, {1'b0, 4'h3, 1'b0, 1'b0});
    end
  endtask

  // Both requesters present a two-beat packet at once; requester 0 wins.
  task automatic test_two_packets();
    logic [3:0] expD[4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic       expL[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int         expA[4] = '{0, 0, 1, 1};
    applyReset();
    q0Data = '{4'hA, 4'hB};  q0Last = '{1'b0, 1'b1};
    q1Data = '{4'hC, 4'hD};  q1Last = '{1'b0, 1'b1};
    runCycles(12);
    assertCount++;
    if (outDataLog.size() != 4 || accLog.size() != 4) begin
      failCount++;
      $display("[TB] FAIL two_count: out beats %0d grants %0d expected 4 and 4", outDataLog.size(), accLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        assertCount++;
        if (outDataLog[i] !== expD[i] || outLastLog[i] !== expL[i] ||
            accLog[i] != expA[i] || selLog[i] !== expA[i][0]) begin
          failCount++;
          $display("[TB] FAIL two_beat%0d: data %h last %b src %0d sel %b expected %h %b %0d",
                   i, outDataLog[i], outLastLog[i], accLog[i], selLog[i], expD[i], expL[i], expA[i]);
        end
      end
    end
    assertCount++;
    if (protoErr != 0) begin
      failCount++;
      $display("[TB] FAIL two_ready_exclusive: got %0d violations expected 0", protoErr);
    end
  endtask

  // Continuous single-beat requests from both sides must alternate.
  task automatic test_alternate();
    logic [3:0] expD[8] = '{4'h1, 4'h9, 4'h2, 4'hA, 4'h3, 4'hB, 4'h4, 4'hC};
    applyReset();
    q0Data = '{4'h1, 4'h2, 4'h3, 4'h4};  q0Last = '{1'b1, 1'b1, 1'b1, 1'b1};
    q1Data = '{4'h9, 4'hA, 4'hB, 4'hC};  q1Last = '{1'b1, 1'b1, 1'b1, 1'b1};
    runCycles(20);
    assertCount++;
    if (outDataLog.size() != 8 || accLog.size() != 8) begin
      failCount++;
      $display("[TB] FAIL alt_count: out beats %0d grants %0d expected 8 and 8", outDataLog.size(), accLog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        assertCount++;
        if (outDataLog[i] !== expD[i] || accLog[i] != (i % 2)) begin
          failCount++;
          $display("[TB] FAIL alt_beat%0d: data %h src %0d expected %h %0d", i, outDataLog[i], accLog[i], expD[i], i % 2);
        end
      end
    end
  endtask

  // Downstream stalls for three cycles in the middle of a packet.
  task automatic test_stall();
    logic [3:0] expD[4] = '{4'h5, 4'h6, 4'h7, 4'h8};
    logic       expL[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    applyReset();
    q0Data = '{4'h5, 4'h6, 4'h7, 4'h8};
    q0Last = '{1'b0, 1'b0, 1'b0, 1'b1};
    runCycles(3);
    Out_Ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      runCycles(1);
      assertCount++;
      if ({Out_Valid, Out_Data, Out_Last, In0_Ready} !== {1'b1, 4'h6, 1'b0, 1'b0}) begin
        failCount++;
        $display("[TB] FAIL stall_hold%0d: got %b expected %b", s, {Out_Valid, Out_Data, Out_Last, In0_Ready}, {1'b1, 4'h6, 1'b0, 1'b0});
      end
    end
    Out_Ready = 1'b1;
    runCycles(10);
    assertCount++;
    if (outDataLog.size() != 4) begin
      failCount++;
      $display("[TB] FAIL stall_count: got %0d beats expected 4", outDataLog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        assertCount++;
        if (outDataLog[i] !== expD[i] || outLastLog[i] !== expL[i]) begin
          failCount++;
          $display("[TB] FAIL stall_beat%0d: data %h last %b expected %h %b", i, outDataLog[i], outLastLog[i], expD[i], expL[i]);
        end
      end
    end
  endtask

  // Ten-beat packet from requester 1 is cut after eight beats; the pending
  // requester 0 packet goes next, then the remaining two beats.
  task automatic test_truncation();
    logic [3:0] expD[11] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF, 4'h9, 4'hA};
    logic       expL[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int         expA[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    applyReset();
    for (int i = 1; i <= 10; i++) begin
      q1Data.push_back(4'(i));
      q1Last.push_back(i == 10);
    end
    runCycles(3);
    q0Data.push_back(4'hF);
    q0Last.push_back(1'b1);
    runCycles(30);
    assertCount++;
    if (outDataLog.size() != 11 || accLog.size() != 11) begin
      failCount++;
      $display("[TB] FAIL trunc_count: out beats %0d grants %0d expected 11 and 11", outDataLog.size(), accLog.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        assertCount++;
        if (outDataLog[i] !== expD[i] || outLastLog[i] !== expL[i] || accLog[i] != expA[i]) begin
          failCount++;
          $display("[TB] FAIL trunc_beat%0d: data %h last %b src %0d expected %h %b %0d",
                   i, outDataLog[i], outLastLog[i], accLog[i], expD[i], expL[i], expA[i]);
        end
      end
    end
    assertCount++;
    if (truncCount != 1 || truncData !== 4'h8 || truncLast !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL trunc_pulse: pulses %0d data %h last %b expected 1 8 1", truncCount, truncData, truncLast);
    end
  endtask

  // Reset asserted mid-packet between clock edges.
  task automatic test_reset_midpacket();
    applyReset();
    q0Data = '{4'h1, 4'h2, 4'h3, 4'h4};
    q0Last = '{1'b0, 1'b0, 1'b0, 1'b1};
    runCycles(3);
    #2 Rst_n = 1'b0;
    #1;
    assertCount++;
    if ({Out_Valid, Out_Data, Out_Last, Sel, Busy, Truncated, In0_Ready, In1_Ready} !== 11'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs: got %b expected %b",
               {Out_Valid, Out_Data, Out_Last, Sel, Busy, Truncated, In0_Ready, In1_Ready}, 11'b0);
    end
    In0_Valid = 1'b0;
    q0Data.delete(); q0Last.delete();
    outDataLog.delete(); outLastLog.delete();
    accLog.delete(); selLog.delete();
    #7 Rst_n = 1'b1;
    assertCount++;
    if (Busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_idle: Busy got %b expected 0", Busy);
    end
    q0Data = '{4'hE};  q0Last = '{1'b1};
    q1Data = '{4'h3};  q1Last = '{1'b1};
    runCycles(6);
    assertCount++;
    if (accLog.size() != 2 || outDataLog.size() != 2) begin
      failCount++;
      $display("[TB] FAIL midreset_count: grants %0d beats %0d expected 2 and 2", accLog.size(), outDataLog.size());
    end else if (accLog[0] != 0 || outDataLog[0] !== 4'hE || outDataLog[1] !== 4'h3) begin
      failCount++;
      $display("[TB] FAIL midreset_tie: first src %0d data %h %h expected 0 e 3", accLog[0], outDataLog[0], outDataLog[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_two_packets();
    test_alternate();
    test_stall();
    test_truncation();
    test_reset_midpacket();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
